// File: rtl/adder_unit_pkg.sv
// Shared defaults and the segment-count helper for the segmented registered adder.
package adder_unit_pkg;

  localparam int N_DEFAULT     = 25;
  localparam int SEG_W_DEFAULT = 5;

  function automatic int seg_count(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/adder_unit_segment.sv
// One combinational ripple segment of the carry chain: {cout, s} = a + b + cin.
module adder_segment
  import adder_unit_pkg::*;
#(
  parameter int W = SEG_W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_unit.sv
// Registered N-bit unsigned adder built from chained ripple segments; outputs hold on idle
// cycles so the datapath does not toggle without a valid word.
module adder_unit
  import adder_unit_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         out_valid
);

  localparam int NSEG = seg_count(N, SEG_W);

  logic [NSEG:0]  carry;
  logic [N-1:0]   add_s;
  logic [N-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           valid_q;

  assign carry[0] = 1'b0;

  // The last segment takes whatever width remains when N is not a multiple of SEG_W.
  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    localparam int LO = gi * SEG_W;
    localparam int W  = ((LO + SEG_W) > N) ? (N - LO) : SEG_W;

    adder_segment #(.W(W)) u_seg (
      .a    (input1[LO +: W]),
      .b    (input2[LO +: W]),
      .cin  (carry[gi]),
      .s    (add_s[LO +: W]),
      .cout (carry[gi+1])
    );
  end

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    if (in_valid) begin
      sum_d   = add_s;
      carry_d = carry[NSEG];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_unit.sv
// Scoreboard bench for adder_unit at N=25/SEG_W=5 and N=8/SEG_W=3 driven side by side.
module tb_adder_unit;

  localparam int NA = 25;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [NA-1:0] input1, input2;
  logic [NA-1:0] sum_a;
  logic          carry_a, valid_a;
  logic [NB-1:0] sum_b;
  logic          carry_b, valid_b;

  always #5 clk = ~clk;

  adder_unit #(.N(NA), .SEG_W(5)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .input1    (input1),
    .input2    (input2),
    .sum       (sum_a),
    .carry_out (carry_a),
    .out_valid (valid_a)
  );

  adder_unit #(.N(NB), .SEG_W(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .input1    (input1[NB-1:0]),
    .input2    (input2[NB-1:0]),
    .sum       (sum_b),
    .carry_out (carry_b),
    .out_valid (valid_b)
  );

  logic [NA:0] q_a[$];
  logic [NB:0] q_b[$];
  logic [NA:0] last_a;
  logic [NB:0] last_b;
  logic        exp_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and compare both instances against the scoreboard / held values.
  task automatic step_check();
    @(posedge clk);
    #1;
    chk("a_valid", 64'(valid_a), 64'(exp_v));
    chk("b_valid", 64'(valid_b), 64'(exp_v));
    if (valid_a) begin
      chk("a_sbq", 64'(q_a.size() > 0), 64'd1);
      if (q_a.size() > 0) last_a = q_a.pop_front();
    end
    if (valid_b) begin
      chk("b_sbq", 64'(q_b.size() > 0), 64'd1);
      if (q_b.size() > 0) last_b = q_b.pop_front();
    end
    chk("a_sum",  64'(sum_a),   64'(last_a[NA-1:0]));
    chk("a_cout", 64'(carry_a), 64'(last_a[NA]));
    chk("b_sum",  64'(sum_b),   64'(last_b[NB-1:0]));
    chk("b_cout", 64'(carry_b), 64'(last_b[NB]));
    $display("txn v=%0b a=%07h b=%07h -> sumA=%07h cA=%0b sumB=%02h cB=%0b",
             exp_v, input1, input2, sum_a, carry_a, sum_b, carry_b);
  endtask

  // exp_a is the required (N+1)-bit result for the 25-bit instance.
  task automatic drive_exp(input logic [NA-1:0] a, input logic [NA-1:0] b, input logic [NA:0] exp_a);
    logic [NB-1:0] al, bl;
    al = a[NB-1:0];
    bl = b[NB-1:0];
    in_valid = 1'b1;
    input1   = a;
    input2   = b;
    exp_v    = 1'b1;
    q_a.push_back(exp_a);
    q_b.push_back({1'b0, al} + {1'b0, bl});
    step_check();
  endtask

  task automatic drive(input logic [NA-1:0] a, input logic [NA-1:0] b);
    drive_exp(a, b, {1'b0, a} + {1'b0, b});
  endtask

  task automatic idle();
    in_valid = 1'b0;
    input1   = 'x;
    input2   = 'x;
    exp_v    = 1'b0;
    step_check();
  endtask

  initial begin
    logic [49:0] pat;
    logic [NA-1:0] ra, rb;
    int sel;

    rst      = 1'b1;
    in_valid = 1'b0;
    input1   = '0;
    input2   = '0;
    last_a   = '0;
    last_b   = '0;
    exp_v    = 1'b0;
    #1;
    chk("rst_sum", 64'(sum_a), 64'd0);
    chk("rst_val", 64'(valid_a), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Wrap and carry, simple add, full wrap to zero.
    drive_exp(25'h1FFFFC0, 25'h1FFFFFF, 26'h3FFFFBF);
    drive_exp(25'h0000FFF, 25'h0000000, 26'h0000FFF);
    drive_exp(25'h1FFFFFF, 25'h0000001, 26'h2000000);

    // Carry crossing each segment boundary.
    for (int k = 1; k < 5; k++) begin
      ra = (25'd1 << (5 * k)) - 25'd1;
      drive_exp(ra, 25'd1, 26'd1 << (5 * k));
    end

    // Asynchronous reset while out_valid is high, with a word in flight.
    in_valid = 1'b1;
    input1   = 25'h0ABCDEF;
    input2   = 25'h0123456;
    #3 rst = 1'b1;
    #1;
    chk("arst_sum",   64'(sum_a),   64'd0);
    chk("arst_cout",  64'(carry_a), 64'd0);
    chk("arst_valid", 64'(valid_a), 64'd0);
    chk("arst_b_sum", 64'(sum_b),   64'd0);
    @(posedge clk);
    #1;
    chk("rsth_valid", 64'(valid_a), 64'd0);
    chk("rsth_sum",   64'(sum_a),   64'd0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    last_a = '0;
    last_b = '0;
    idle();
    drive(25'h0000001, 25'h0000002);

    // Burst of 20 rotating words followed by a 7-cycle gap.
    pat = 50'h3FFFF0000FFFF;
    for (int i = 0; i < 20; i++) begin
      drive(pat[NA-1:0], pat[49:NA]);
      pat = {pat[46:0], pat[49:47]};
    end
    for (int i = 0; i < 7; i++) idle();

    // Random operands with random valid, biased toward extreme values now and then.
    for (int i = 0; i < 10000; i++) begin
      sel = $urandom_range(0, 7);
      ra  = NA'($urandom());
      rb  = NA'($urandom());
      if (sel == 0) ra = '1;
      if (sel == 1) rb = ~ra;
      if ($urandom_range(0, 3) != 0) drive(ra, rb);
      else idle();
    end
    idle();

    chk("a_sb_empty", 64'(q_a.size()), 64'd0);
    chk("b_sb_empty", 64'(q_b.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
